turn_signal_sequencer: RTL and testbench

//  Owns the turn-indicator sequence: turns driver switches, hazard switch and lane-change taps into

---
 rtl/turn_signal_sequencer_pkg.sv | 27 ++
 rtl/turn_signal_sequencer_if.sv | 22 ++
 rtl/turn_signal_sequencer_blink_timer.sv | 54 +++++
 rtl/turn_signal_sequencer.sv | 109 ++++++++++
 tb/tb_turn_signal_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/turn_signal_sequencer_pkg.sv
// Shared state encoding and helpers for the turn-indicator sequencer
// and the light/dashboard blocks that decode its state.
package turn_signal_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEFT   = 3'd1;
    localparam state_t ST_RIGHT  = 3'd2;
    localparam state_t ST_HAZARD = 3'd3;
    localparam state_t ST_LANE_L = 3'd4;
    localparam state_t ST_LANE_R = 3'd5;

    function automatic logic is_active(input state_t s);
        return (s == ST_LEFT) || (s == ST_RIGHT) || (s == ST_HAZARD) ||
               (s == ST_LANE_L) || (s == ST_LANE_R);
    endfunction

    function automatic logic is_lane(input state_t s);
        return (s == ST_LANE_L) || (s == ST_LANE_R);
    endfunction

    function automatic logic is_level(input state_t s);
        return (s == ST_LEFT) || (s == ST_RIGHT) || (s == ST_HAZARD);
    endfunction

endpackage

// File: rtl/turn_signal_sequencer_if.sv
// Switch/tap inputs and lamp/click outputs of the turn-indicator sequencer.
interface turn_signal_sequencer_if;
    logic sw_left;
    logic sw_right;
    logic sw_hazard;
    logic tap_left;
    logic tap_right;
    logic turn_left;
    logic turn_right;
    logic hazard_on;
    logic click;

    modport master (
        output sw_left, sw_right, sw_hazard, tap_left, tap_right,
        input  turn_left, turn_right, hazard_on, click
    );

    modport slave (
        input  sw_left, sw_right, sw_hazard, tap_left, tap_right,
        output turn_left, turn_right, hazard_on, click
    );
endinterface

// File: rtl/turn_signal_sequencer_blink_timer.sv
// Half-period timer: holds cnt and lamp phase, strobes on every phase toggle
// and produces the registered click one cycle after the toggle.
module turn_signal_sequencer_blink_timer #(
    parameter int HALF_PERIOD = 25_000_000,
    parameter int CNT_W       = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_start,
    input  logic i_stop,
    output logic o_phase,
    output logic o_toggle,
    output logic o_click
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             r_click;
    logic             w_toggle;

    // The toggle is judged on the current state, so a lane that ends on this
    // edge still produces its final click.
    assign w_toggle = i_active && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_click <= 1'b0;
        end else begin
            r_click <= w_toggle;
            if (i_stop) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (i_start) begin
                r_cnt   <= '0;
                r_phase <= 1'b1;
            end else if (w_toggle) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else if (i_active) begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign o_phase  = r_phase;
    assign o_toggle = w_toggle;
    assign o_click  = r_click;

endmodule

// File: rtl/turn_signal_sequencer.sv
// Turn-indicator sequencer: switch/hazard/lane-tap arbitration, lane blink
// counting and lamp decode around a shared half-period blink timer.
//
// state  | meaning
// IDLE   | lamps dark, timer cleared
// LEFT   | left switch held, left lamp blinks
// RIGHT  | right switch held, right lamp blinks
// HAZARD | hazard switch held, both lamps blink in phase
// LANE_L | lane-change tap left, LANE_BLINKS blinks then IDLE
// LANE_R | lane-change tap right, LANE_BLINKS blinks then IDLE
module turn_signal_sequencer
    import turn_signal_sequencer_pkg::*;
#(
    parameter int HALF_PERIOD = 25_000_000,
    parameter int LANE_BLINKS = 3,
    parameter int CNT_W       = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    turn_signal_sequencer_if.slave   bus
);

    localparam int BW = (LANE_BLINKS < 2) ? 1 : $clog2(LANE_BLINKS + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(LANE_BLINKS);

    state_t          r_state;
    state_t          w_next_state;
    logic            w_tap_restart;
    logic            w_start;
    logic            w_phase;
    logic            w_toggle;
    logic            w_click;
    logic [BW-1:0]   r_blink_cnt;
    logic            w_turn_left;
    logic            w_turn_right;
    logic            w_hazard_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_tap_restart = 1'b0;
        if (bus.sw_hazard) begin
            w_next_state = ST_HAZARD;
        end else if (bus.sw_left && bus.sw_right) begin
            w_next_state = ST_IDLE;
        end else if (bus.sw_left) begin
            w_next_state = ST_LEFT;
        end else if (bus.sw_right) begin
            w_next_state = ST_RIGHT;
        end else if (is_level(r_state)) begin
            w_next_state = ST_IDLE;
        end else if (bus.tap_left ^ bus.tap_right) begin
            w_next_state  = bus.tap_left ? ST_LANE_L : ST_LANE_R;
            w_tap_restart = 1'b1;
        end else if (is_lane(r_state) && w_toggle && !w_phase &&
                     (r_blink_cnt == BLINK_LAST)) begin
            w_next_state = ST_IDLE;
        end
    end

    // Any change of state, or a repeated tap, restarts the blink with the lamp ON.
    assign w_start = is_active(w_next_state) &&
                     ((w_next_state != r_state) || w_tap_restart);

    turn_signal_sequencer_blink_timer #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_blink_timer (
        .clk      (clk),
        .rst      (rst),
        .i_active (is_active(r_state)),
        .i_start  (w_start),
        .i_stop   (!is_active(w_next_state)),
        .o_phase  (w_phase),
        .o_toggle (w_toggle),
        .o_click  (w_click)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
        end else if (!is_lane(w_next_state) || w_start) begin
            r_blink_cnt <= '0;
        end else if (w_toggle && w_phase && (r_blink_cnt != BLINK_LAST)) begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        w_turn_left  = w_phase && ((r_state == ST_LEFT) || (r_state == ST_LANE_L) ||
                                   (r_state == ST_HAZARD));
        w_turn_right = w_phase && ((r_state == ST_RIGHT) || (r_state == ST_LANE_R) ||
                                   (r_state == ST_HAZARD));
        w_hazard_on  = (r_state == ST_HAZARD);
    end

    assign bus.turn_left  = w_turn_left;
    assign bus.turn_right = w_turn_right;
    assign bus.hazard_on  = w_hazard_on;
    assign bus.click      = w_click;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Directed and randomized checks of the turn-indicator sequencer against a
// cycle-age reference model (HALF_PERIOD=4, LANE_BLINKS=2).
module tb_turn_signal_sequencer;

    localparam int HP = 4;
    localparam int LB = 2;

    // model modes: 0 idle, 1 left, 2 right, 3 hazard, 4 lane left, 5 lane right
    localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3, M_LL = 4, M_LR = 5;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    int   m_mode = M_IDLE;
    int   m_age  = 0;
    bit   m_click = 1'b0;

    turn_signal_sequencer_if bus ();

    turn_signal_sequencer #(
        .HALF_PERIOD (HP),
        .LANE_BLINKS (LB),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    // Lamp is ON during even half-periods counted from entry; a lane lasts
    // exactly LB full ON/OFF cycles; a click follows every half-period boundary.
    task automatic model_edge(input bit l, input bit r, input bit hz, input bit tl, input bit tr);
        int nm;
        bit restart;
        bit tog;
        tog     = (m_mode != M_IDLE) && ((m_age % HP) == HP - 1);
        restart = 1'b0;
        if (hz)                    nm = M_HAZ;
        else if (l && r)           nm = M_IDLE;
        else if (l)                nm = M_LEFT;
        else if (r)                nm = M_RIGHT;
        else if (m_mode inside {M_LEFT, M_RIGHT, M_HAZ}) nm = M_IDLE;
        else if (tl != tr) begin
            nm      = tl ? M_LL : M_LR;
            restart = 1'b1;
        end else begin
            nm = m_mode;
            if ((nm == M_LL || nm == M_LR) && (m_age + 1 == 2 * HP * LB)) nm = M_IDLE;
        end
        m_click = tog;
        if (nm == M_IDLE)                    m_age = 0;
        else if (nm != m_mode || restart)    m_age = 0;
        else                                 m_age++;
        m_mode = nm;
    endtask

    task automatic check_outputs();
        bit on;
        on = (m_mode != M_IDLE) && (((m_age / HP) % 2) == 0);
        chk("turn_left",  bus.turn_left,  on && (m_mode inside {M_LEFT, M_HAZ, M_LL}));
        chk("turn_right", bus.turn_right, on && (m_mode inside {M_RIGHT, M_HAZ, M_LR}));
        chk("hazard_on",  bus.hazard_on,  m_mode == M_HAZ);
        chk("click",      bus.click,      m_click);
    endtask

    task automatic step(input bit l, input bit r, input bit hz, input bit tl, input bit tr);
        @(negedge clk);
        bus.sw_left   = l;
        bus.sw_right  = r;
        bus.sw_hazard = hz;
        bus.tap_left  = tl;
        bus.tap_right = tr;
        @(posedge clk);
        model_edge(l, r, hz, tl, tr);
        #1;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        bit sl, sr, sh;
        int clicks;
        rst           = 1'b1;
        bus.sw_left   = 1'b0;
        bus.sw_right  = 1'b0;
        bus.sw_hazard = 1'b0;
        bus.tap_left  = 1'b0;
        bus.tap_right = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_left",  bus.turn_left,  1'b0);
        chk("reset_right", bus.turn_right, 1'b0);
        chk("reset_haz",   bus.hazard_on,  1'b0);
        chk("reset_click", bus.click,      1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_steps(3);

        // left switch held: 4 on / 4 off, clicks at every boundary
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        idle_steps(2);

        // lane tap right: two blinks then back to idle, counting clicks
        clicks = 0;
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 18; i++) begin
            step(0, 0, 0, 0, 0);
            if (bus.click === 1'b1) clicks++;
        end
        total++;
        assert (clicks == 2 * LB) else begin
            bad++;
            $error("FAIL lane_clicks observed=%0d expected=%0d", clicks, 2 * LB);
        end

        // hazard over left, then hazard released with left still held
        for (int i = 0; i < 6; i++)  step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++)  step(1, 0, 0, 0, 0);
        idle_steps(2);

        // conflicting switches and simultaneous taps
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        idle_steps(4);

        // repeated tap during a lane restarts the blink count
        step(0, 0, 0, 1, 0);
        idle_steps(9);
        step(0, 0, 0, 1, 0);
        idle_steps(20);

        // reset mid-blink drops lamps without waiting for a clock edge
        for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_left",  bus.turn_left,  1'b0);
        chk("rst_async_right", bus.turn_right, 1'b0);
        chk("rst_async_haz",   bus.hazard_on,  1'b0);
        m_mode  = M_IDLE;
        m_age   = 0;
        m_click = 1'b0;
        @(negedge clk);
        bus.sw_left   = 1'b0;
        bus.sw_hazard = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_steps(4);

        // randomized: slowly changing switches, sparse taps
        sl = 0; sr = 0; sh = 0;
        for (int i = 0; i < 800; i++) begin
            int t;
            if ($urandom_range(0, 29) == 0) sl = ~sl;
            if ($urandom_range(0, 29) == 0) sr = ~sr;
            if ($urandom_range(0, 59) == 0) sh = ~sh;
            t = $urandom_range(0, 19);
            step(sl, sr, sh, t == 0 || t == 2, t == 1 || t == 2);
        end
        idle_steps(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
